// File: rtl/pixel_pkg.sv
// Shared types and helpers for the NeoPixel frame sequencer.
// Holds the FSM state encoding and the RGB-to-GRB wire-order reorder.
package pixel_pkg;

    localparam int BITS_PER_PIXEL = 24;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SYNC    = 3'd1,
        S_LOAD    = 3'd2,
        S_SEND    = 3'd3,
        S_WAIT_HI = 3'd4,
        S_WAIT_LO = 3'd5,
        S_LATCH   = 3'd6
    } state_t;

    // The strip expects green first, then red, then blue.
    function automatic logic [23:0] rgb_to_grb(input logic [23:0] rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

endpackage

// File: rtl/pixel_latch_timer.sv
// Loadable down-counter with terminal-count flag; serves both the latch gap
// and the mid-frame stall detector.
module pixel_latch_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_tc = (r_count == '0);

endmodule

// File: rtl/pixel_frame_ctrl.sv
// Frame sequencer: pulls NUM_PIXELS RGB words, feeds them bit by bit in GRB
// order to the pixel bit writer, then holds a latch gap before frame_done.
module pixel_frame_ctrl
    import pixel_pkg::*;
#(
    parameter int CLK_HZ     = 12_000_000,
    parameter int NUM_PIXELS = 8,
    parameter int LATCH_US   = 80
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        bit_value,
    output logic        bit_valid,
    input  logic        bit_busy,
    output logic        frame_busy,
    output logic        frame_done,
    output logic        underrun
);

    localparam int          LATCH_CYCLES = CLK_HZ / 1_000_000 * LATCH_US;
    localparam int          STALL_CYCLES = LATCH_CYCLES / 2;
    localparam logic [31:0] LATCH_LOAD   = 32'(LATCH_CYCLES);
    // Loaded one short so the flag is seen on the STALL_CYCLES-th stalled cycle.
    localparam logic [31:0] STALL_LOAD   = (STALL_CYCLES > 0) ? 32'(STALL_CYCLES - 1) : 32'd0;
    localparam logic [15:0] LAST_PIX     = 16'(NUM_PIXELS - 1);
    localparam logic [4:0]  LAST_BIT     = 5'(BITS_PER_PIXEL - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [23:0] r_sreg;
    logic [4:0]  r_bit_cnt;
    logic [15:0] r_pix_cnt;
    logic        r_bit_hold;
    logic        r_underrun;

    logic        w_tmr_load;
    logic [31:0] w_tmr_load_val;
    logic        w_tmr_en;
    logic        w_tmr_tc;
    logic        w_stalled;

    pixel_latch_timer #(
        .WIDTH(32)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_tmr_load),
        .i_load_val(w_tmr_load_val),
        .i_en      (w_tmr_en),
        .o_tc      (w_tmr_tc)
    );

    // Stalls only matter once the frame is under way (second pixel onward).
    assign w_stalled = (r_state == S_LOAD) && !pix_valid && (r_pix_cnt != 16'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_tmr_load     = 1'b0;
        w_tmr_load_val = LATCH_LOAD;
        w_tmr_en       = 1'b0;
        pix_ready      = 1'b0;
        bit_valid      = 1'b0;
        bit_value      = r_bit_hold;
        frame_busy     = (r_state != S_IDLE);
        frame_done     = 1'b0;
        underrun       = r_underrun;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_SYNC;
                end
            end
            S_SYNC: begin
                if (!bit_busy) begin
                    w_state_next   = S_LOAD;
                    w_tmr_load     = 1'b1;
                    w_tmr_load_val = STALL_LOAD;
                end
            end
            S_LOAD: begin
                pix_ready = 1'b1;
                w_tmr_en  = w_stalled;
                if (pix_valid) begin
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                bit_valid    = 1'b1;
                bit_value    = r_sreg[23];
                w_state_next = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (bit_busy) begin
                    w_state_next = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!bit_busy) begin
                    if (r_bit_cnt != 5'd0) begin
                        w_state_next = S_SEND;
                    end else if (r_pix_cnt != LAST_PIX) begin
                        w_state_next   = S_LOAD;
                        w_tmr_load     = 1'b1;
                        w_tmr_load_val = STALL_LOAD;
                    end else begin
                        w_state_next   = S_LATCH;
                        w_tmr_load     = 1'b1;
                        w_tmr_load_val = LATCH_LOAD;
                    end
                end
            end
            S_LATCH: begin
                w_tmr_en = 1'b1;
                if (w_tmr_tc) begin
                    frame_done   = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sreg     <= '0;
            r_bit_cnt  <= '0;
            r_pix_cnt  <= '0;
            r_bit_hold <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_underrun <= 1'b0;
                        r_pix_cnt  <= 16'd0;
                    end
                end
                S_LOAD: begin
                    if (pix_valid) begin
                        r_sreg    <= rgb_to_grb(pix_data);
                        r_bit_cnt <= LAST_BIT;
                    end else if (w_stalled && w_tmr_tc) begin
                        r_underrun <= 1'b1;
                    end
                end
                S_SEND: begin
                    r_bit_hold <= r_sreg[23];
                end
                S_WAIT_LO: begin
                    if (!bit_busy) begin
                        if (r_bit_cnt != 5'd0) begin
                            r_sreg    <= {r_sreg[22:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt - 5'd1;
                        end else if (r_pix_cnt != LAST_PIX) begin
                            r_pix_cnt <= r_pix_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_frame_ctrl.sv
// Randomised bench for pixel_frame_ctrl with a busy-pacing writer model and a
// stream-level scoreboard of expected GRB bits, latch gap and underrun.
`timescale 1ns/1ps
module tb_pixel_frame_ctrl;

    localparam int NPIX       = 2;
    localparam int LATCH_CYC  = 960;
    localparam int STALL_LIM  = LATCH_CYC / 2;
    localparam int WAIT_LIMIT = 10000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] pix_data = '0;
    logic        pix_valid = 1'b0;
    logic        bit_busy = 1'b0;
    logic        pix_ready, bit_value, bit_valid, frame_busy, frame_done, underrun;

    int checks = 0;
    int errors = 0;

    pixel_frame_ctrl #(
        .CLK_HZ    (12_000_000),
        .NUM_PIXELS(NPIX),
        .LATCH_US  (80)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .bit_value (bit_value),
        .bit_valid (bit_valid),
        .bit_busy  (bit_busy),
        .frame_busy(frame_busy),
        .frame_done(frame_done),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Writer model: busy rises 5 cycles after a valid, stays high 150 cycles. No reset.
    int wcnt = 0;
    always @(posedge clk) begin
        if (wcnt == 0) begin
            if (bit_valid) wcnt <= 1;
        end else begin
            wcnt <= (wcnt == 155) ? 0 : wcnt + 1;
        end
        bit_busy <= (wcnt >= 4 && wcnt < 154);
    end

    // Scoreboard state
    bit          exp_q[$];
    int          cyc = 0;
    int          hs_cnt = 0;
    int          nbits = 0;
    int          stall_run = 0;
    int          last_fall = 0;
    int          last_gap = 0;
    int          frames_done = 0;
    logic        model_active = 1'b0;
    logic        exp_underrun = 1'b0;
    logic        last_bit = 1'b0;
    logic        prev_busy = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_done = 1'b0;
    logic [47:0] cur_stream = '0;
    logic [47:0] last_stream = '0;

    always @(negedge clk) begin
        logic was_active;
        cyc++;
        if (!rst_n) begin
            check("reset_outputs", {pix_ready, bit_value, bit_valid, frame_busy, frame_done, underrun}, 6'b0);
            exp_q.delete();
            hs_cnt = 0; nbits = 0; stall_run = 0;
            model_active = 1'b0; exp_underrun = 1'b0; last_bit = 1'b0;
            cur_stream = '0;
        end else begin
            was_active = model_active;
            check("frame_busy", frame_busy, model_active);
            check("underrun_spurious", underrun && !exp_underrun, 1'b0);
            check("done_pulse_width", frame_done && prev_done, 1'b0);
            if (pix_ready) check("ready_outside_load", (exp_q.size() != 0) || !model_active, 1'b0);
            if (bit_valid) begin
                check("valid_while_busy", bit_busy, 1'b0);
                check("valid_back_to_back", prev_valid, 1'b0);
                check("bit_without_pixel", exp_q.size() == 0, 1'b0);
                if (exp_q.size() != 0) check("bit_value", bit_value, exp_q.pop_front());
                last_bit = bit_value;
                cur_stream = {cur_stream[46:0], bit_value};
                nbits++;
            end else begin
                check("bit_value_hold", bit_value, last_bit);
            end
            if (pix_ready && !pix_valid && hs_cnt >= 1) stall_run++;
            else stall_run = 0;
            if (stall_run >= STALL_LIM) exp_underrun = 1'b1;
            if (pix_ready && pix_valid) begin
                hs_cnt++;
                check("too_many_handshakes", hs_cnt > NPIX, 1'b0);
                for (int i = 7; i >= 0; i--) exp_q.push_back(pix_data[8 + i]);
                for (int i = 7; i >= 0; i--) exp_q.push_back(pix_data[16 + i]);
                for (int i = 7; i >= 0; i--) exp_q.push_back(pix_data[i]);
            end
            if (prev_busy && !bit_busy) last_fall = cyc;
            if (frame_done) begin
                check("done_outside_frame", model_active, 1'b1);
                check("done_handshakes", hs_cnt, NPIX);
                check("done_bits", nbits, 24 * NPIX);
                check("done_bits_left", exp_q.size(), 0);
                check("latch_gap", cyc - last_fall, LATCH_CYC + 1);
                check("underrun_at_done", underrun, exp_underrun);
                last_stream = cur_stream;
                last_gap = cyc - last_fall;
                frames_done++;
                model_active = 1'b0;
            end
            if (start && !was_active) begin
                model_active = 1'b1;
                exp_underrun = 1'b0;
                hs_cnt = 0; nbits = 0; stall_run = 0;
                cur_stream = '0;
            end
        end
        prev_busy  = bit_busy;
        prev_valid = bit_valid;
        prev_done  = frame_done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: present data at once; mode 1: wait for ready, then stall gap cycles.
    task automatic feed_pixel(input logic [23:0] d, input int mode, input int gap);
        int n;
        if (mode == 1) begin
            pix_valid = 1'b0;
            n = 0;
            while (!pix_ready && n < WAIT_LIMIT) begin tick(); n++; end
            repeat (gap) tick();
        end
        pix_data  = d;
        pix_valid = 1'b1;
        n = 0;
        while (!pix_ready && n < WAIT_LIMIT) begin tick(); n++; end
        check("ready_timeout", pix_ready, 1'b1);
        tick();
    endtask

    task automatic wait_done(input bit start_on_done);
        int n;
        n = 0;
        while (!frame_done && n < WAIT_LIMIT) begin tick(); n++; end
        check("done_timeout", frame_done, 1'b1);
        if (start_on_done) start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        if (start_on_done) check("start_on_done_ignored", frame_busy, 1'b0);
    endtask

    task automatic finish_frame(input bit mid_start, input bit start_on_done,
                                input int stall, input bit keep_valid, input int first);
        for (int p = first; p < NPIX; p++) begin
            if (keep_valid) feed_pixel(24'($urandom), 0, 0);
            else if (p == 1 && stall > 0) feed_pixel(24'($urandom), 1, stall);
            else feed_pixel(24'($urandom), int'($urandom_range(0, 1)), int'($urandom_range(0, 20)));
            if (p == 0 && mid_start) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            if (!keep_valid && $urandom_range(0, 1) == 1) pix_valid = 1'b0;
        end
        if (keep_valid) pix_data = 24'($urandom);
        else pix_valid = 1'b0;
        wait_done(start_on_done);
    endtask

    task automatic run_frame(input bit mid_start, input bit start_on_done,
                             input int stall, input bit keep_valid);
        int n;
        n = 0;
        while (frame_busy && n < WAIT_LIMIT) begin tick(); n++; end
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_clears_underrun", underrun, 1'b0);
        check("start_accepted", frame_busy, 1'b1);
        finish_frame(mid_start, start_on_done, stall, keep_valid, 0);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n;
        int f0;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("idle_after_reset", {pix_ready, bit_valid, frame_busy, frame_done, underrun}, 5'b0);

        // Two-pixel frame with first pixel already presented: minimum latency.
        pix_data  = 24'hFF0000;
        pix_valid = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check("t1_sync_no_ready", pix_ready, 1'b0);
        tick();
        check("t1_load_ready", pix_ready, 1'b1);
        check("t1_no_bit_yet", bit_valid, 1'b0);
        tick();
        check("t1_first_bit_latency", bit_valid, 1'b1);
        check("t1_first_bit_value", bit_value, 1'b0);
        feed_pixel(24'h00FF01, 0, 0);
        pix_valid = 1'b0;
        wait_done(1'b0);
        check("t1_stream", last_stream, 48'h00FF00FF0001);
        check("t2_latch_gap", last_gap, LATCH_CYC + 1);

        // start mid-frame and on the frame_done cycle are both ignored.
        f0 = frames_done;
        run_frame(1'b1, 1'b1, 0, 1'b0);
        repeat (20) tick();
        check("t3_single_frame", frames_done - f0, 1);
        check("t3_still_idle", frame_busy, 1'b0);

        run_frame(1'b0, 1'b0, 0, 1'b0);

        // Long stall before the second pixel raises sticky underrun.
        run_frame(1'b0, 1'b0, 500, 1'b0);
        check("t4_underrun_sticky", underrun, 1'b1);
        run_frame(1'b0, 1'b0, 0, 1'b0);
        check("t4_underrun_cleared", underrun, 1'b0);

        // Asynchronous reset while waiting for busy to rise.
        start = 1'b1;
        tick();
        start = 1'b0;
        feed_pixel(24'($urandom), 0, 0);
        pix_valid = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_reset", {pix_ready, bit_valid, bit_value, frame_busy, frame_done, underrun}, 6'b0);
        n = 0;
        while (!bit_busy && n < 50) begin tick(); n++; end
        check("t5_writer_busy", bit_busy, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (bit_busy && n < WAIT_LIMIT) begin
            check("t5_sync_hold", pix_ready, 1'b0);
            tick();
            n++;
        end
        check("t5_busy_fell", bit_busy, 1'b0);
        tick();
        check("t5_load_after_busy", pix_ready, 1'b1);
        finish_frame(1'b0, 1'b0, 0, 1'b0, 0);

        // pix_valid held high throughout: exactly NPIX handshakes.
        pix_valid = 1'b1;
        f0 = frames_done;
        run_frame(1'b0, 1'b0, 0, 1'b1);
        repeat (20) tick();
        check("t6_one_frame", frames_done - f0, 1);
        check("t6_no_ready_idle", pix_ready, 1'b0);
        pix_valid = 1'b0;

        repeat (5) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
